// File: rtl/ahb_uart_tx_satellite_if.sv
// AHB-Lite slave-side bus bundle for the UART transmit satellite.
// The master drives the request; the satellite returns data and the ready/response pair.
interface ahb_uart_tx_satellite_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (output hsel, haddr, htrans, hwrite, hsize, hwdata,
                  input  hrdata, hready, hresp);
  modport slave  (input  hsel, haddr, htrans, hwrite, hsize, hwdata,
                  output hrdata, hready, hresp);
endinterface

// File: rtl/ahb_uart_tx_satellite.sv
// Memory-mapped 8N1 transmitter: AHB writes fill a TX FIFO that a baud-timed serializer drains onto tx.
// Full-FIFO writes to DATA are held off with wait states until the serializer frees an entry.
module ahb_uart_tx_satellite #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic                    clk,
  input  logic                    rst,
  ahb_uart_tx_satellite_if.slave  bus,
  output logic                    tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          dphase_q, err_q, write_q;
  logic [3:0]    addr_q;
  logic [2:0]    size_q;
  logic [15:0]   baud_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q;
  logic [15:0]   cnt_q, fdiv_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic full, empty, bit_end, pop, push, bad, wr_data, wr_baud, stall, hready, accept;
  logic [31:0] status, rdata;
  logic unused_bits;

  assign unused_bits = ^{bus.haddr[31:4], bus.hwdata[31:16], bus.htrans[0]};

  assign full    = count_q == CW'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign bit_end = cnt_q == fdiv_q - 16'd1;
  assign pop     = !empty && (state_q == S_IDLE || (state_q == S_STOP && bit_end));

  assign bad     = dphase_q && (!(addr_q == 4'h0 || addr_q == 4'h4 || addr_q == 4'h8) ||
                                size_q != 3'b010);
  assign wr_data = dphase_q && !bad && write_q && addr_q == 4'h0;
  assign wr_baud = dphase_q && !bad && write_q && addr_q == 4'h8;
  // A full FIFO only stalls if the serializer is not popping on this very edge.
  assign stall   = wr_data && full && !pop;
  assign push    = wr_data && !stall;
  assign hready  = !(bad && !err_q) && !stall;
  assign accept  = bus.hsel && bus.htrans[1] && hready;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    status    = '0;
    status[0] = full;
    status[1] = empty;
    status[2] = state_q != S_IDLE;
    status[7:4] = 4'(count_q);
    rdata     = '0;
    if (dphase_q && !bad && !write_q) begin
      case (addr_q)
        4'h4:    rdata = status;
        4'h8:    rdata = {16'd0, baud_q};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.hrdata = rdata;
  assign bus.hready = hready;
  assign bus.hresp  = bad;
  assign tx         = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dphase_q <= 1'b0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      baud_q   <= 16'(DEFAULT_DIV);
    end else begin
      err_q <= bad && !err_q;
      if (hready) begin
        dphase_q <= accept;
        if (accept) begin
          addr_q  <= bus.haddr[3:0];
          write_q <= bus.hwrite;
          size_q  <= bus.hsize;
        end
      end
      if (wr_baud) baud_q <= (bus.hwdata[15:0] == 16'd0) ? 16'd1 : bus.hwdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.hwdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // fdiv_q latches BAUDDIV at each frame start so a mid-frame write cannot stretch bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fdiv_q  <= 16'(DEFAULT_DIV);
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_START;
            shift_q <= mem_q[rptr_q];
            fdiv_q  <= baud_q;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else cnt_q <= cnt_q + 16'd1;
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else cnt_q <= cnt_q + 16'd1;
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              state_q <= S_START;
              shift_q <= mem_q[rptr_q];
              fdiv_q  <= baud_q;
              tx_q    <= 1'b0;
            end else state_q <= S_IDLE;
          end else cnt_q <= cnt_q + 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_uart_tx_satellite.sv
// Bench for ahb_uart_tx_satellite: a frame-timeline model (byte queue + frame start/period arithmetic)
// is compared against tx/hready/hresp/hrdata every cycle, plus hand-computed literal expectations.
module tb_ahb_uart_tx_satellite;
  localparam int DEPTH = 8;
  localparam int DDIV  = 868;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;

  ahb_uart_tx_satellite_if bus();

  ahb_uart_tx_satellite #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data phase currently presented by the driver, as seen by the model.
  bit          dp_v  = 1'b0;
  bit          dp_w  = 1'b0;
  logic [3:0]  dp_a  = 4'h0;
  logic [2:0]  dp_s  = 3'b010;
  logic [31:0] dp_wd = 32'h0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Model: a frame is just (start cycle, period, byte); tx follows from (cycle-start)/period.
  initial begin : model
    byte unsigned mq[$];
    bit m_busy, m_err, bad, pop, done, push, wdat;
    int m_fstart, m_fdiv, m_cyc;
    logic [7:0] m_fbyte;
    logic [15:0] m_baud;
    logic exp_rdy, exp_resp, exp_tx;
    logic [31:0] st;
    m_busy = 0; m_err = 0; m_fstart = 0; m_fdiv = 1; m_cyc = 0; m_fbyte = 0; m_baud = 16'(DDIV);
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_busy = 0; m_err = 0; m_baud = 16'(DDIV);
        check("rst_tx", tx, 1);
        check("rst_hready", bus.hready, 1);
        check("rst_hresp", bus.hresp, 0);
      end else begin
        bad  = dp_v && !((dp_a == 4'h0 || dp_a == 4'h4 || dp_a == 4'h8) && dp_s == 3'b010);
        pop  = 0;
        done = 0;
        if (!m_busy) pop = mq.size() > 0;
        else if (m_cyc - m_fstart == 10 * m_fdiv - 1) begin
          pop  = mq.size() > 0;
          done = !pop;
        end
        wdat     = dp_v && !bad && dp_w && dp_a == 4'h0;
        push     = wdat && (mq.size() < DEPTH || pop);
        exp_rdy  = 1'b1;
        exp_resp = 1'b0;
        if (bad) begin
          exp_resp = 1'b1;
          exp_rdy  = m_err;
        end else if (wdat) exp_rdy = push;
        exp_tx = m_busy ? frame_bit(m_fbyte, (m_cyc - m_fstart) / m_fdiv) : 1'b1;
        check("tx", tx, exp_tx);
        check("hready", bus.hready, exp_rdy);
        check("hresp", bus.hresp, exp_resp);
        if (dp_v && !bad && !dp_w) begin
          st = 32'h0;
          if (dp_a == 4'h4)
            st = {24'd0, 4'(mq.size()), 1'b0, m_busy, mq.size() == 0, mq.size() == DEPTH};
          else if (dp_a == 4'h8) st = {16'd0, m_baud};
          check("hrdata", bus.hrdata, st);
        end
        m_err = bad && !m_err;
        if (pop) begin
          m_fbyte  = mq.pop_front();
          m_fstart = m_cyc + 1;
          m_fdiv   = int'(m_baud);
          m_busy   = 1;
        end else if (done) m_busy = 0;
        if (push) mq.push_back(dp_wd[7:0]);
        if (dp_v && !bad && dp_w && dp_a == 4'h8)
          m_baud = (dp_wd[15:0] == 16'd0) ? 16'd1 : dp_wd[15:0];
      end
      m_cyc++;
    end
  end

  // Called at posedge+1; non-pipelined single transfer, returns after the completing edge (+1).
  task automatic xfer(input logic [3:0] a, input bit w, input logic [2:0] s, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits, output logic resp);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = {28'h0, a}; bus.hwrite = w; bus.hsize = s;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wd;
    dp_v = 1'b1; dp_a = a; dp_w = w; dp_s = s; dp_wd = wd;
    waits = 0;
    @(negedge clk);
    while (bus.hready !== 1'b1 && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 2000) check("xfer_timeout_hready", bus.hready, 1);
    rd = bus.hrdata;
    resp = bus.hresp;
    @(posedge clk); #1;
    dp_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the start bit, then captures n consecutive tx samples.
  task automatic sample_frame(input int n, output logic [63:0] v, output bit found);
    int t;
    t = 0; v = '0; found = 0;
    while (t < 300 && !found) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
      t++;
    end
    if (found) begin
      v[0] = tx;
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        v[i] = tx;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    int w, lows;
    logic r;
    logic [63:0] v, e;
    bit found;
    int a5_bits[10];
    a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    bus.hsel = 0; bus.htrans = 2'b00; bus.haddr = 0; bus.hwrite = 0; bus.hsize = 3'b010; bus.hwdata = 0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_tx", tx, 1);
    check("reset_hready", bus.hready, 1);
    check("reset_hresp", bus.hresp, 0);
    check("reset_hrdata", bus.hrdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    xfer(4'h4, 0, 3'b010, 0, rd, w, r);
    check("reset_status", rd, 32'h2);
    xfer(4'h8, 0, 3'b010, 0, rd, w, r);
    check("reset_bauddiv", rd, 32'd868);

    // Single 0xA5 frame at BAUDDIV=4.
    xfer(4'h8, 1, 3'b010, 32'd4, rd, w, r);
    fork
      begin
        xfer(4'h0, 1, 3'b010, 32'hA5, rd, w, r);
        xfer(4'h4, 0, 3'b010, 0, rd, w, r);
        check("status_busy_in_frame", rd, 32'h6);
      end
      sample_frame(40, v, found);
    join
    check("a5_start_found", found, 1);
    e = '0;
    for (int i = 0; i < 40; i++) e[i] = a5_bits[i/4][0];
    check("a5_waveform", v, e);
    xfer(4'h4, 0, 3'b010, 0, rd, w, r);
    check("status_after_a5", rd, 32'h2);

    // Ten back-to-back writes: the tenth must stall until a frame boundary.
    for (int i = 0; i < 10; i++) begin
      xfer(4'h0, 1, 3'b010, 32'h10 + i, rd, w, r);
      if (i == 9) check("burst_tenth_stalled", w > 0, 1);
      else check("burst_no_stall", w, 0);
    end
    xfer(4'h4, 0, 3'b010, 0, rd, w, r);
    check("status_full_busy", rd, 32'h85);
    idle(400);
    xfer(4'h4, 0, 3'b010, 0, rd, w, r);
    check("status_drained", rd, 32'h2);

    // Error responses: bad offset and bad size.
    xfer(4'hC, 0, 3'b010, 0, rd, w, r);
    check("err_off_waits", w, 1);
    check("err_off_hresp", r, 1);
    xfer(4'h0, 1, 3'b000, 32'h55, rd, w, r);
    check("err_size_waits", w, 1);
    check("err_size_hresp", r, 1);
    xfer(4'h4, 0, 3'b010, 0, rd, w, r);
    check("status_after_err", rd, 32'h2);

    // BAUDDIV=0 stores 1; 0xFF frame is one low cycle then high.
    xfer(4'h8, 1, 3'b010, 32'd0, rd, w, r);
    xfer(4'h8, 0, 3'b010, 0, rd, w, r);
    check("bauddiv_zero_reads_1", rd, 32'd1);
    fork
      xfer(4'h0, 1, 3'b010, 32'hFF, rd, w, r);
      sample_frame(12, v, found);
    join
    check("ff_start_found", found, 1);
    check("ff_waveform", v[11:0], 12'hFFE);

    // Reset in the middle of a frame with three bytes queued.
    xfer(4'h8, 1, 3'b010, 32'd4, rd, w, r);
    for (int i = 0; i < 4; i++) xfer(4'h0, 1, 3'b010, 32'h11 + i, rd, w, r);
    lows = 0;
    while (tx !== 1'b0 && lows < 100) begin
      @(negedge clk);
      lows++;
    end
    check("midframe_low_seen", tx, 0);
    #2 rst = 1'b1;
    #1 check("async_rst_tx", tx, 1);
    check("async_rst_hready", bus.hready, 1);
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    xfer(4'h4, 0, 3'b010, 0, rd, w, r);
    check("status_after_rst", rd, 32'h2);
    xfer(4'h8, 0, 3'b010, 0, rd, w, r);
    check("bauddiv_after_rst", rd, 32'd868);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_frames_after_rst", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
